// File: rtl/mb_booth_pkg.sv
// Shared types for the radix-4 Booth multiplier family.
// Holds the FSM state and Booth select encodings, plus the digit-count helper.
package mb_booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_POS1 = 3'd1,
    SEL_POS2 = 3'd2,
    SEL_NEG1 = 3'd3,
    SEL_NEG2 = 3'd4
  } booth_sel_t;

  // One extra digit so zero-extended unsigned operands get their top bit covered.
  function automatic int ndig(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/mb_booth_r4_enc.sv
// Radix-4 Booth recoder: maps the 3-bit window {q[1], q[0], q[-1]} to a multiple select.
// Purely combinational; zero_o takes priority over sel_2x_o and negate_o.
module mb_booth_r4_enc
  import mb_booth_pkg::*;
(
  input  logic [2:0] win_i,
  output logic       sel_2x_o,
  output logic       negate_o,
  output logic       zero_o
);

  booth_sel_t sel;

  always_comb begin
    sel = SEL_ZERO;
    case (win_i)
      3'b001, 3'b010: sel = SEL_POS1;
      3'b011:         sel = SEL_POS2;
      3'b100:         sel = SEL_NEG2;
      3'b101, 3'b110: sel = SEL_NEG1;
      default:        sel = SEL_ZERO;
    endcase
  end

  assign sel_2x_o = (sel == SEL_POS2) || (sel == SEL_NEG2);
  assign negate_o = (sel == SEL_NEG1) || (sel == SEL_NEG2);
  assign zero_o   = (sel == SEL_ZERO);

endmodule

// File: rtl/mb_booth_r4_iter.sv
// Iterative radix-4 Booth multiplier, one digit per clock, signed/unsigned per operation.
// Define MB_EARLY_TERM_EN to finish as soon as the remaining multiplier digits are all zero.
module mb_booth_r4_iter
  import mb_booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mx,
  input  logic [WIDTH-1:0]   my,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int NDIG = ndig(WIDTH);
  localparam int CW   = $clog2(NDIG);
  localparam int PW   = 2 * WIDTH;
  localparam int QW   = WIDTH + 2;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  state_t         state_q;
  logic [PW-1:0]  m_q, m_d;
  logic [QW-1:0]  q_q, q_d;
  logic           qm1_q, qm1_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [CW-1:0]  cnt_q;
  logic [PW-1:0]  product_q;
  logic           out_valid_q;
  logic           in_ready_q;
  logic           busy_q;

  logic           sel_2x;
  logic           negate;
  logic           zero;
  logic [PW-1:0]  addend;
  logic           calc_last;

  mb_booth_r4_enc u_enc (
    .win_i    ({q_q[1:0], qm1_q}),
    .sel_2x_o (sel_2x),
    .negate_o (negate),
    .zero_o   (zero)
  );

  // Conditional-negate adder: subtraction is invert-plus-carry-in on the selected multiple.
  always_comb begin
    addend = zero ? '0 : (sel_2x ? {m_q[PW-2:0], 1'b0} : m_q);
    acc_d  = acc_q + (addend ^ {PW{negate}}) + PW'(negate);
    m_d    = {m_q[PW-3:0], 2'b00};
    q_d    = {{2{q_q[QW-1]}}, q_q[QW-1:2]};
    qm1_d  = q_q[1];
  end

`ifdef MB_EARLY_TERM_EN
  logic rest_zero;
  // All-equal window bits beyond this point can only recode to zero digits.
  assign rest_zero = (&{q_d, qm1_d}) | ~(|{q_d, qm1_d});
  assign calc_last = (cnt_q == LAST_DIG) || rest_zero;
`else
  assign calc_last = (cnt_q == LAST_DIG);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      m_q         <= '0;
      q_q         <= '0;
      qm1_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            m_q        <= {{WIDTH{signed_mode & mx[WIDTH-1]}}, mx};
            q_q        <= {{2{signed_mode & my[WIDTH-1]}}, my};
            qm1_q      <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= ST_CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          m_q   <= m_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CW'(1);
          if (calc_last) begin
            state_q     <= ST_DONE;
            product_q   <= acc_d;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mb_booth_r4_iter.sv
// Self-checking bench for mb_booth_r4_iter (WIDTH=16) against a plain-arithmetic product model.
// Inputs driven and outputs sampled on the falling edge; latency measured in rising edges after accept.
module tb_mb_booth_r4_iter;

  localparam int W = 16;

  logic           CLK = 1'b0;
  logic           RST;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   mx;
  logic [W-1:0]   my;
  logic           signed_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int total = 0;
  int bad   = 0;

  mb_booth_r4_iter #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mx          (mx),
    .my          (my),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm);
    longint x;
    longint y;
    x = sm ? longint'($signed(a)) : longint'(a);
    y = sm ? longint'($signed(b)) : longint'(b);
    return 32'(x * y);
  endfunction

  // Fixed build: always W/2+1 digits. Early-term build: fewest digits k whose 2k-bit
  // signed range holds the extended multiplier.
  function automatic int ref_lat(input logic [W-1:0] b, input logic sm);
`ifdef MB_EARLY_TERM_EN
    longint y;
    y = sm ? longint'($signed(b)) : longint'(b);
    for (int k = 1; k < W / 2 + 1; k++) begin
      if (y >= -(longint'(1) << (2 * k - 1)) && y < (longint'(1) << (2 * k - 1)))
        return k;
    end
    return W / 2 + 1;
`else
    return (b == b) ? W / 2 + 1 : 0;
`endif
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        input string tag);
    int lat;
    logic [31:0] exp;
    exp = ref_prod(a, b, sm);
    @(negedge CLK);
    check({tag, ".in_ready"}, in_ready, 1);
    in_valid    = 1'b1;
    mx          = a;
    my          = b;
    signed_mode = sm;
    @(posedge CLK);
    @(negedge CLK);
    in_valid    = 1'b0;
    mx          = W'($urandom);
    my          = W'($urandom);
    signed_mode = 1'($urandom);
    check({tag, ".busy"}, busy, 1);
    check({tag, ".in_ready_busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    check({tag, ".latency"}, lat, ref_lat(b, sm));
    check({tag, ".product"}, product, exp);
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    int lat;
    RST         = 1'b1;
    in_valid    = 1'b1;
    out_ready   = 1'b0;
    mx          = 16'h1234;
    my          = 16'h4321;
    signed_mode = 1'b0;

    repeat (3) @(negedge CLK);
    check("rst.out_valid", out_valid, 0);
    check("rst.product", product, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.busy", busy, 0);
    RST      = 1'b0;
    in_valid = 1'b0;

    run_op(16'hFFFF, 16'hFFFF, 1'b0, "unsigned_max");
    run_op(16'h8000, 16'h8000, 1'b1, "s_min_min");
    run_op(16'hFFFF, 16'h0002, 1'b1, "s_neg1_x2");
    run_op(16'h7FFF, 16'h8000, 1'b1, "s_max_min");
    run_op(16'h8000, 16'h8000, 1'b0, "u_8000_8000");
    run_op(16'h0000, 16'hABCD, 1'b1, "zero_mx");

    // Back-pressure: hold the result and offer a competing operation meanwhile.
    @(negedge CLK);
    in_valid = 1'b1; mx = 16'h00FF; my = 16'h0101; signed_mode = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; mx = 16'h1111; my = 16'h2222; signed_mode = 1'b1;
      check("bp.out_valid", out_valid, 1);
      check("bp.product", product, ref_prod(16'h00FF, 16'h0101, 1'b0));
      check("bp.in_ready", in_ready, 0);
      @(negedge CLK);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    out_ready = 1'b0;
    check("bp.out_valid_drop", out_valid, 0);
    @(negedge CLK);
    check("bp.second_not_taken", busy, 0);

    // Abort mid-calculation with an asynchronous reset pulse.
    @(negedge CLK);
    in_valid = 1'b1; mx = 16'h1234; my = 16'h5678; signed_mode = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("abort.out_valid", out_valid, 0);
    check("abort.product", product, 0);
    check("abort.in_ready", in_ready, 1);
    check("abort.busy", busy, 0);
    @(negedge CLK);
    RST = 1'b0;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (out_valid) lat++;
    end
    check("abort.no_stale_valid", lat, 0);
    run_op(16'h1234, 16'h5678, 1'b0, "abort_redo");

    run_op(16'hBEEF, 16'h0001, 1'b0, "et_my1");
    run_op(16'h1357, 16'hFFFF, 1'b1, "et_myneg1");

    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      if (i % 4 == 0) b = W'($urandom_range(0, 15));
      if (i % 4 == 1) b = W'(-$urandom_range(1, 15));
      run_op(a, b, 1'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
